// File: rtl/pipe_pkg.sv
// Shared definitions for the IF/ID/EXE pipeline slice.
// Holds the datapath widths, the ALU control encodings used by the control
// unit and the ALU, the ID/EXE payload struct and the ALU control decoder.
package pipe_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RN_W   = 5;
    localparam int unsigned ALUC_W = 4;
    localparam int unsigned SHAMT_W = 5;

    // Canonical ALU control encodings (bit 3 is don't-care except for shifts).
    localparam logic [ALUC_W-1:0] ALUC_ADD = 4'b0000;
    localparam logic [ALUC_W-1:0] ALUC_SUB = 4'b0100;
    localparam logic [ALUC_W-1:0] ALUC_AND = 4'b0001;
    localparam logic [ALUC_W-1:0] ALUC_OR  = 4'b0101;
    localparam logic [ALUC_W-1:0] ALUC_XOR = 4'b0010;
    localparam logic [ALUC_W-1:0] ALUC_LUI = 4'b0110;
    localparam logic [ALUC_W-1:0] ALUC_SLL = 4'b0011;
    localparam logic [ALUC_W-1:0] ALUC_SRL = 4'b0111;
    localparam logic [ALUC_W-1:0] ALUC_SRA = 4'b1011;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_LUI,
        OP_SLL,
        OP_SRL,
        OP_SRA
    } alu_op_e;

    // Decode-stage payload carried into the EXE stage.
    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic              wmem;
        logic              aluimm;
        logic [ALUC_W-1:0] aluc;
        logic [RN_W-1:0]   rn;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   fwda;
        logic [XLEN-1:0]   fwdb;
    } idexe_t;

    // Map a 4-bit ALU control word (with its don't-care bits) onto an operation.
    function automatic alu_op_e alu_decode(input logic [ALUC_W-1:0] aluc);
        alu_op_e op;
        op = OP_ADD;
        if (aluc[1:0] == 2'b11) begin
            // Shift group: bit 3 selects arithmetic regardless of bit 2.
            if (aluc[3]) begin
                op = OP_SRA;
            end else if (aluc[2]) begin
                op = OP_SRL;
            end else begin
                op = OP_SLL;
            end
        end else begin
            case (aluc[2:0])
                3'b000:  op = OP_ADD;
                3'b100:  op = OP_SUB;
                3'b001:  op = OP_AND;
                3'b101:  op = OP_OR;
                3'b010:  op = OP_XOR;
                3'b110:  op = OP_LUI;
                default: op = OP_ADD;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/pipe_alu.sv
// Combinational ALU for the EXE stage. No internal state, no flags.
// Ports:
//   aluc : ALU control word
//   a    : operand A (also supplies the shift amount in a[4:0])
//   b    : operand B (the value shifted for SLL/SRL/SRA, source for LUI)
//   r    : result, modulo 2^32
module pipe_alu
    import pipe_pkg::*;
(
    input  logic [ALUC_W-1:0] aluc,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   r
);

    logic [SHAMT_W-1:0] shamt;
    alu_op_e            op;

    assign shamt = a[SHAMT_W-1:0];
    assign op    = alu_decode(aluc);

    // Operation select; carries and overflow wrap silently.
    always_comb begin
        r = '0;
        case (op)
            OP_ADD:  r = XLEN'(a + b);
            OP_SUB:  r = XLEN'(a - b);
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_LUI:  r = {b[15:0], 16'h0000};
            OP_SLL:  r = b << shamt;
            OP_SRL:  r = b >> shamt;
            OP_SRA:  r = XLEN'($signed(b) >>> shamt);
            default: r = XLEN'(a + b);
        endcase
    end

endmodule

// File: rtl/pipe_if_id_exe.sv
// IF/ID and ID/EXE pipeline registers with the EXE-stage ALU.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   do_in             : instruction word from instruction memory
//   ido               : IF/ID registered instruction
//   wreg, m2reg, wmem, aluimm, aluc, out, signextendimm, fwdaout, fwdbout
//                     : decode-stage controls and operands
//   ewreg, em2reg, ewmem, ealuimm, ealuc, ern, esignextendimm, efwdaout, efwdbout
//                     : EXE-stage registered copies
//   b                 : ALU operand B, muxed externally
//   r                 : ALU result (combinational)
module pipe_if_id_exe
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   do_in,
    output logic [XLEN-1:0]   ido,
    input  logic              wreg,
    input  logic              m2reg,
    input  logic              wmem,
    input  logic              aluimm,
    input  logic [ALUC_W-1:0] aluc,
    input  logic [RN_W-1:0]   out,
    input  logic [XLEN-1:0]   signextendimm,
    input  logic [XLEN-1:0]   fwdaout,
    input  logic [XLEN-1:0]   fwdbout,
    output logic              ewreg,
    output logic              em2reg,
    output logic              ewmem,
    output logic              ealuimm,
    output logic [ALUC_W-1:0] ealuc,
    output logic [RN_W-1:0]   ern,
    output logic [XLEN-1:0]   esignextendimm,
    output logic [XLEN-1:0]   efwdaout,
    output logic [XLEN-1:0]   efwdbout,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   r
);

    logic [XLEN-1:0] ido_d, ido_q;
    idexe_t          idexe_d, idexe_q;

    // Next-state: both stages load unconditionally every cycle.
    always_comb begin
        ido_d          = do_in;
        idexe_d        = '0;
        idexe_d.wreg   = wreg;
        idexe_d.m2reg  = m2reg;
        idexe_d.wmem   = wmem;
        idexe_d.aluimm = aluimm;
        idexe_d.aluc   = aluc;
        idexe_d.rn     = out;
        idexe_d.imm    = signextendimm;
        idexe_d.fwda   = fwdaout;
        idexe_d.fwdb   = fwdbout;
    end

    // IF/ID register; reset value 0 is a NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ido_q <= '0;
        end else begin
            ido_q <= ido_d;
        end
    end

    // ID/EXE register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idexe_q <= '0;
        end else begin
            idexe_q <= idexe_d;
        end
    end

    assign ido            = ido_q;
    assign ewreg          = idexe_q.wreg;
    assign em2reg         = idexe_q.m2reg;
    assign ewmem          = idexe_q.wmem;
    assign ealuimm        = idexe_q.aluimm;
    assign ealuc          = idexe_q.aluc;
    assign ern            = idexe_q.rn;
    assign esignextendimm = idexe_q.imm;
    assign efwdaout       = idexe_q.fwda;
    assign efwdbout       = idexe_q.fwdb;

    // ALU sees only registered EXE state plus the live external operand B.
    pipe_alu u_alu (
        .aluc (idexe_q.aluc),
        .a    (idexe_q.fwda),
        .b    (b),
        .r    (r)
    );

endmodule

// File: tb/tb_pipe_if_id_exe.sv
// Directed self-checking bench for pipe_if_id_exe.
module tb_pipe_if_id_exe;
    import pipe_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] do_in;
    logic [31:0] ido;
    logic        wreg, m2reg, wmem, aluimm;
    logic [3:0]  aluc;
    logic [4:0]  out;
    logic [31:0] signextendimm, fwdaout, fwdbout;
    logic        ewreg, em2reg, ewmem, ealuimm;
    logic [3:0]  ealuc;
    logic [4:0]  ern;
    logic [31:0] esignextendimm, efwdaout, efwdbout;
    logic [31:0] b;
    logic [31:0] r;

    int tests_run;
    int tests_failed;

    pipe_if_id_exe dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .do_in          (do_in),
        .ido            (ido),
        .wreg           (wreg),
        .m2reg          (m2reg),
        .wmem           (wmem),
        .aluimm         (aluimm),
        .aluc           (aluc),
        .out            (out),
        .signextendimm  (signextendimm),
        .fwdaout        (fwdaout),
        .fwdbout        (fwdbout),
        .ewreg          (ewreg),
        .em2reg         (em2reg),
        .ewmem          (ewmem),
        .ealuimm        (ealuimm),
        .ealuc          (ealuc),
        .ern            (ern),
        .esignextendimm (esignextendimm),
        .efwdaout       (efwdaout),
        .efwdbout       (efwdbout),
        .b              (b),
        .r              (r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load ALU control and operand A into the EXE stage.
    task automatic load_alu(input logic [3:0] c, input logic [31:0] a);
        aluc    = c;
        fwdaout = a;
        tick();
    endtask

    // Apply operand B and check the combinational result.
    task automatic alu_chk(input string tag, input logic [31:0] bv, input logic [31:0] exp);
        b = bv;
        #1;
        check(tag, r, exp);
    endtask

    logic [31:0] words [3];

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        do_in = 32'h0; wreg = 0; m2reg = 0; wmem = 0; aluimm = 0;
        aluc = 4'h0; out = 5'h0; signextendimm = 32'h0;
        fwdaout = 32'h0; fwdbout = 32'h0; b = 32'h0;

        // Reset state
        #1;
        check("rst_ido", ido, 32'h0);
        check("rst_ealuc", {28'h0, ealuc}, 32'h0);
        #1;
        rst_n = 1'b1;

        // IF/ID: value appears only after the edge
        do_in = 32'h8C22_0004;
        #1;
        check("ifid_before_edge", ido, 32'h0);
        tick();
        check("ifid_after_edge", ido, 32'h8C22_0004);
        words[0] = 32'h0000_0020;
        words[1] = 32'hAC43_0008;
        words[2] = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            do_in = words[i];
            tick();
            check($sformatf("ifid_b2b%0d", i), ido, words[i]);
        end

        // ID/EXE
        wreg = 1; m2reg = 1; wmem = 0; aluc = 4'b0000; aluimm = 1;
        out = 5'd3; signextendimm = 32'hFFFF_FFFC; fwdaout = 32'h10; fwdbout = 32'h55;
        tick();
        check("ewreg", {31'h0, ewreg}, 32'h1);
        check("em2reg", {31'h0, em2reg}, 32'h1);
        check("ewmem", {31'h0, ewmem}, 32'h0);
        check("ealuimm", {31'h0, ealuimm}, 32'h1);
        check("ealuc", {28'h0, ealuc}, 32'h0);
        check("ern", {27'h0, ern}, 32'd3);
        check("esignextendimm", esignextendimm, 32'hFFFF_FFFC);
        check("efwdaout", efwdaout, 32'h10);
        check("efwdbout", efwdbout, 32'h55);
        alu_chk("add_lw", 32'hFFFF_FFFC, 32'h0000_000C);
        alu_chk("add_wrap", 32'hFFFF_FFF5, 32'h0000_0005);

        // Logic and arithmetic
        load_alu(4'b0001, 32'hF0F0_F0F0);
        alu_chk("and", 32'h0FF0_0FF0, 32'h00F0_00F0);
        load_alu(4'b0101, 32'hF0F0_F0F0);
        alu_chk("or", 32'h0FF0_0FF0, 32'hFFF0_FFF0);
        load_alu(4'b1010, 32'hF0F0_F0F0);
        alu_chk("xor_alias", 32'h0FF0_0FF0, 32'hFF00_FF00);
        load_alu(4'b0100, 32'h1);
        alu_chk("sub", 32'h2, 32'hFFFF_FFFF);
        load_alu(4'b1000, 32'h7);
        alu_chk("add_alias", 32'h9, 32'h10);

        // Shifts
        load_alu(4'b0011, 32'h4);
        alu_chk("sll", 32'h8000_0010, 32'h0000_0100);
        load_alu(4'b0111, 32'h4);
        alu_chk("srl", 32'h8000_0010, 32'h0800_0001);
        load_alu(4'b1011, 32'h4);
        alu_chk("sra", 32'h8000_0010, 32'hF800_0001);
        load_alu(4'b0011, 32'h24);
        alu_chk("sll_trunc", 32'h8000_0010, 32'h0000_0100);
        load_alu(4'b0111, 32'h24);
        alu_chk("srl_trunc", 32'h8000_0010, 32'h0800_0001);
        load_alu(4'b1111, 32'h24);
        alu_chk("sra_trunc_alias", 32'h8000_0010, 32'hF800_0001);
        load_alu(4'b1011, 32'h20);
        alu_chk("sra_zero", 32'h8765_4321, 32'h8765_4321);
        load_alu(4'b0011, 32'h0);
        alu_chk("sll_zero", 32'h8765_4321, 32'h8765_4321);
        load_alu(4'b0110, 32'hFFFF_FFFF);
        alu_chk("lui", 32'h0000_1234, 32'h1234_0000);

        // Mid-operation reset with nonzero inputs
        do_in = 32'hDEAD_BEEF; wreg = 1; m2reg = 1; wmem = 1; aluimm = 1;
        aluc = 4'b0101; out = 5'd31; signextendimm = 32'h1111_1111;
        fwdaout = 32'h2222_2222; fwdbout = 32'h3333_3333; b = 32'h4444_4444;
        tick();
        check("pre_rst_ido", ido, 32'hDEAD_BEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ido", ido, 32'h0);
        check("mid_rst_ctrl", {28'h0, ewreg, em2reg, ewmem, ealuimm}, 32'h0);
        check("mid_rst_ealuc", {28'h0, ealuc}, 32'h0);
        check("mid_rst_ern", {27'h0, ern}, 32'h0);
        check("mid_rst_imm", esignextendimm, 32'h0);
        check("mid_rst_a", efwdaout, 32'h0);
        check("mid_rst_b", efwdbout, 32'h0);
        alu_chk("rst_r_add", 32'h5, 32'h5);
        tick();
        check("rst_held_ido", ido, 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ido", ido, 32'hDEAD_BEEF);
        check("post_rst_ern", {27'h0, ern}, 32'd31);
        alu_chk("post_rst_or", 32'h4444_4444, 32'h6666_6666);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
